vpipe_dec3: RTL and testbench



---
 rtl/vpipe_dec_pkg.sv | 23 ++
 rtl/vpipe_dec_slice.sv | 40 ++++
 rtl/vpipe_dec3.sv | 109 ++++++++++
 tb/tb_vpipe_dec3.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpipe_dec_pkg.sv
// Shared types, defaults and the reference decode function for the vpipe_dec3
// decode pipeline (inverse of the 2x+1 encoder).
package vpipe_dec_pkg;

  localparam int VPIPE_DEC_W_DEFAULT = 4;

  typedef struct packed {
    logic                           valid;
    logic                           tag;
    logic                           err;
    logic [VPIPE_DEC_W_DEFAULT-1:0] data;
  } stage_t;

  // Expected decode of an encoded word y: ((y-1) mod 2^W) >> 1.
  function automatic logic [VPIPE_DEC_W_DEFAULT-1:0] dec_ref(
    input logic [VPIPE_DEC_W_DEFAULT-1:0] y
  );
    logic [VPIPE_DEC_W_DEFAULT-1:0] d;
    d = y - VPIPE_DEC_W_DEFAULT'(1);
    return d >> 1;
  endfunction

endpackage

// File: rtl/vpipe_dec_slice.sv
// One elastic register slice: holds valid/tag/err/data until the next stage
// takes it. Loads only when the upstream stage advances into it.
module vpipe_dec_slice #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         in_tag,
  input  logic         in_err,
  input  logic [W-1:0] in_data,
  input  logic         down_ready,
  output logic         valid,
  output logic         tag,
  output logic         err,
  output logic [W-1:0] data,
  output logic         adv
);

  assign adv = valid & down_ready;

  // The parent only asserts load when this slot is empty or advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= 1'b0;
      err   <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= in_tag;
      err   <= in_err;
      data  <= in_data;
    end else if (adv) begin
      valid <= 1'b0;
      tag   <= 1'b0;
    end
  end

endmodule

// File: rtl/vpipe_dec3.sv
// Three-stage elastic decode pipeline recovering x from y = 2x+1, with a one-hot
// tracking tag. Optional refinement checker enabled by VPIPE_DEC_CHECK_EN.
module vpipe_dec3
  import vpipe_dec_pkg::*;
#(
  parameter int W = VPIPE_DEC_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_tag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err,
  output logic         out_tag,
  output logic         track_busy,
  output logic         chk_fail
);

  // Handshake: a word moves across a boundary in any cycle where the sender's
  // valid and the receiver's ready are both high; valid never depends on ready.
  logic         v1, v2, v3;
  logic         t1, t2, t3;
  logic         e1, e2, e3;
  logic         adv1, adv2, adv3;
  logic [W-1:0] s1_data, s2_data, s3_data;
  logic [W-1:0] s2_in, s3_in;
  logic         accept, retire, tag_in;

  assign retire   = adv3 & t3;
  assign in_ready = !v1 | adv1;
  assign accept   = in_valid & in_ready;
  // A new tag is honoured when idle, or when the current one retires this cycle.
  assign tag_in   = in_tag & (!track_busy | retire);

  assign s2_in = s1_data - W'(1);
  assign s3_in = s2_data >> 1;

  vpipe_dec_slice #(.W(W)) u_s1 (
    .clk(clk), .rst_n(rst_n), .load(accept),
    .in_tag(tag_in), .in_err(~in_data[0]), .in_data(in_data),
    .down_ready(!v2 | adv2),
    .valid(v1), .tag(t1), .err(e1), .data(s1_data), .adv(adv1)
  );

  vpipe_dec_slice #(.W(W)) u_s2 (
    .clk(clk), .rst_n(rst_n), .load(adv1),
    .in_tag(t1), .in_err(e1), .in_data(s2_in),
    .down_ready(!v3 | adv3),
    .valid(v2), .tag(t2), .err(e2), .data(s2_data), .adv(adv2)
  );

  vpipe_dec_slice #(.W(W)) u_s3 (
    .clk(clk), .rst_n(rst_n), .load(adv2),
    .in_tag(t2), .in_err(e2), .in_data(s3_in),
    .down_ready(out_ready),
    .valid(v3), .tag(t3), .err(e3), .data(s3_data), .adv(adv3)
  );

  assign out_valid = v3;
  assign out_data  = s3_data;
  assign out_err   = e3;
  assign out_tag   = t3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      track_busy <= 1'b0;
    end else if (accept & tag_in) begin
      track_busy <= 1'b1;
    end else if (retire) begin
      track_busy <= 1'b0;
    end
  end

`ifdef VPIPE_DEC_CHECK_EN
  logic [W-1:0] shadow;
  logic [W-1:0] shadow_m1;
  logic [W-1:0] shadow_exp;
  logic         chk_q;

  assign shadow_m1  = shadow - W'(1);
  assign shadow_exp = shadow_m1 >> 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      chk_q  <= 1'b0;
    end else begin
      if (accept & tag_in) shadow <= in_data;
      if (retire && (out_data != shadow_exp || out_err != ~shadow[0])) chk_q <= 1'b1;
    end
  end

  assign chk_fail = chk_q;

  a_one_tag : assert property (@(posedge clk) disable iff (!rst_n)
    track_busy |-> $onehot({t1, t2, t3}));

  a_stall_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid & !out_ready) |=> (out_valid && $stable(out_data) &&
                                  $stable(out_err) && $stable(out_tag)));
`else
  assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_vpipe_dec3.sv
// Directed bench for vpipe_dec3 (W=4): vector table streaming, backpressure,
// tag tracking, mid-stream reset and (when compiled in) the refinement checker.
module tb_vpipe_dec3;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_tag = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         out_tag;
  logic         track_busy;
  logic         chk_fail;

  vpipe_dec3 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_tag(out_tag),
    .track_busy(track_busy), .chk_fail(chk_fail)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  bit          lat_chk = 1'b0;
  logic [5:0]  exp_q[$];   // {tag, err, data}
  int          acc_q[$];   // accept cycle of each queued word
  logic [5:0]  mon_e;
  int          mon_a;

  typedef struct {
    logic [3:0] y;
    logic [3:0] x;
    logic       err;
  } vec_t;

  vec_t       vecs[10];
  logic [3:0] bp_y[4];
  logic [3:0] bp_x[4];
  logic       bp_e[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected no output", out_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = acc_q.pop_front();
        check("out_data", {28'd0, out_data}, {28'd0, mon_e[3:0]});
        check("out_err", {31'd0, out_err}, {31'd0, mon_e[4]});
        check("out_tag", {31'd0, out_tag}, {31'd0, mon_e[5]});
        if (lat_chk) check("latency", cyc - mon_a, 3);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] y, input logic tg, input logic [3:0] ex,
                      input logic ee, input logic et);
    int n;
    in_valid = 1'b1;
    in_data  = y;
    in_tag   = tg;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 expected 1");
    end else begin
      exp_q.push_back({et, ee, ex});
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_tag   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words outstanding expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    int t0;
    int idx;
    int n;

    vecs[0] = '{4'h1, 4'h0, 1'b0};
    vecs[1] = '{4'h3, 4'h1, 1'b0};
    vecs[2] = '{4'h5, 4'h2, 1'b0};
    vecs[3] = '{4'hF, 4'h7, 1'b0};
    vecs[4] = '{4'h0, 4'h7, 1'b1};
    vecs[5] = '{4'h6, 4'h2, 1'b1};
    vecs[6] = '{4'h2, 4'h0, 1'b1};
    vecs[7] = '{4'h8, 4'h3, 1'b1};
    vecs[8] = '{4'h7, 4'h3, 1'b0};
    vecs[9] = '{4'hD, 4'h6, 1'b0};
    bp_y = '{4'h9, 4'hB, 4'hD, 4'hE};
    bp_x = '{4'h4, 4'h5, 4'h6, 4'h6};
    bp_e = '{1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_track_busy", {31'd0, track_busy}, 0);
    check("rst_chk_fail", {31'd0, chk_fail}, 0);
    check("rst_out_data", {28'd0, out_data}, 0);
    check("rst_out_err", {31'd0, out_err}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back vector table, latency and throughput
    lat_chk = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) send(vecs[i].y, 1'b0, vecs[i].x, vecs[i].err, 1'b0);
    check("throughput_cycles", cyc - t0, 10);
    drain();
    lat_chk = 1'b0;

    // Backpressure: 5 stalled cycles with 4 words offered
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    in_data = bp_y[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, (k < 3) ? 1 : 0);
      if (k >= 3) begin
        check("bp_stall_valid", {31'd0, out_valid}, 1);
        check("bp_stall_data", {28'd0, out_data}, 4);
      end
      if (in_ready && idx < 4) begin
        exp_q.push_back({1'b0, bp_e[idx], bp_x[idx]});
        acc_q.push_back(cyc);
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < 4) in_data = bp_y[idx];
      else in_valid = 1'b0;
    end
    out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({1'b0, bp_e[idx], bp_x[idx]});
        acc_q.push_back(cyc);
        idx++;
      end
      @(posedge clk);
      #1;
      if (idx < 4) in_data = bp_y[idx];
      n++;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 4);
    drain();

    // Tag tracking: second tag offered while busy is dropped
    send(4'h9, 1'b1, 4'h4, 1'b0, 1'b1);
    check("tag_busy_set", {31'd0, track_busy}, 1);
    send(4'hB, 1'b1, 4'h5, 1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_tag) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tag_retire_seen", {31'd0, out_valid & out_tag}, 1);
    check("tag_busy_at_retire", {31'd0, track_busy}, 1);
    @(negedge clk);
    check("tag_busy_after_retire", {31'd0, track_busy}, 0);
    drain();

    // Retire and new tagged accept in the same cycle
    send(4'h3, 1'b1, 4'h1, 1'b0, 1'b1);
    send(4'h5, 1'b1, 4'h2, 1'b0, 1'b0);
    send(4'h7, 1'b1, 4'h3, 1'b0, 1'b0);
    send(4'h9, 1'b1, 4'h4, 1'b0, 1'b1);
    check("handover_busy", {31'd0, track_busy}, 1);
    drain();
    check("handover_busy_clear", {31'd0, track_busy}, 0);

    // Reset with three items in flight
    send(4'h1, 1'b1, 4'h0, 1'b0, 1'b1);
    send(4'h3, 1'b0, 4'h1, 1'b0, 1'b0);
    send(4'h5, 1'b0, 4'h2, 1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, out_valid}, 1);
    check("pre_rst_busy", {31'd0, track_busy}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_busy", {31'd0, track_busy}, 0);
    check("mid_rst_chk_fail", {31'd0, chk_fail}, 0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 1);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'h7, 1'b0, 4'h3, 1'b0, 1'b0);
    drain();

`ifdef VPIPE_DEC_CHECK_EN
    // Corrupt S2 data of the tracked word: 5 -> S2 holds 4, forced to F, out 7
    send(4'h5, 1'b1, 4'h7, 1'b0, 1'b1);
    force dut.s2_data = 4'hF;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    release dut.s2_data;
    drain();
    check("chk_fail_set", {31'd0, chk_fail}, 1);
    repeat (3) @(posedge clk);
    #1;
    check("chk_fail_sticky", {31'd0, chk_fail}, 1);
    rst_n = 1'b0;
    #1;
    check("chk_fail_rst", {31'd0, chk_fail}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`else
    check("chk_fail_tied", {31'd0, chk_fail}, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
